// File: rtl/sim_pkg.sv
// Shared state encoding, default parameters and elaboration helpers for the
// simulation controller.
package sim_pkg;

    typedef enum logic [2:0] {
        RST_HOLD = 3'd0,
        RUN      = 3'd1,
        DRAIN    = 3'd2,
        PRINT    = 3'd3,
        DONE     = 3'd4
    } sim_state_e;

    localparam int DEF_NUM_CORES    = 1;
    localparam int DEF_CNT_W        = 32;
    localparam int DEF_RST_CYCLES   = 4;
    localparam int DEF_DRAIN_CYCLES = 3;
    localparam int DEF_TIMEOUT      = 100000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to represent max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) <= max_val) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/sim_cnt.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
module sim_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;
    logic [W-1:0] q_next;

    always_comb begin
        q_next = q_reg;
        if (clr) begin
            q_next = '0;
        end else if (en && (q_reg != '1)) begin
            q_next = q_reg + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/sim_ctrl.sv
// Simulation controller: holds the processor in reset, counts run cycles,
// waits for every core to halt (or a timeout), then requests a dump and stops.
module sim_ctrl
    import sim_pkg::*;
#(
    parameter int NUM_CORES    = DEF_NUM_CORES,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int RST_CYCLES   = DEF_RST_CYCLES,
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
    parameter int TIMEOUT      = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_CORES-1:0] halt,
    output logic                 proc_rst_n,
    output logic                 print,
    input  logic                 print_ack,
    output logic [CNT_W-1:0]     cycle_cnt,
    output logic [NUM_CORES-1:0] halted_mask,
    output logic                 done,
    output logic                 timeout
);

    // One counter serves both RST_HOLD and DRAIN; it is cleared on every state change.
    localparam int PH_MAX = max_int(RST_CYCLES, DRAIN_CYCLES);
    localparam int PH_W   = cnt_width(PH_MAX);
    localparam logic [PH_W-1:0] RST_LAST   = PH_W'(RST_CYCLES - 1);
    localparam logic [PH_W-1:0] DRAIN_LAST = PH_W'(DRAIN_CYCLES - 1);

    sim_state_e state_reg, state_next;
    logic [PH_W-1:0]      phase_cnt;
    logic [CNT_W-1:0]     cnt_q;
    logic [NUM_CORES-1:0] mask_reg, mask_next;
    logic                 timeout_reg, timeout_next;
    logic                 print_reg, done_reg, proc_rst_n_reg;
    logic                 all_halt, timeout_hit;
    logic [63:0]          cnt_plus;

    assign mask_next = (state_reg == RUN) ? (mask_reg | halt) : mask_reg;
    assign all_halt  = &mask_next;

    // Timeout fires on the edge where the counter would land on TIMEOUT; a saturated
    // counter never advances, so it can never reach a limit beyond its range.
    assign cnt_plus    = 64'(cnt_q) + 64'd1;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q != '1) && (cnt_plus == 64'(TIMEOUT));

    always_comb begin
        state_next   = state_reg;
        timeout_next = timeout_reg;
        case (state_reg)
            RST_HOLD: begin
                if (phase_cnt == RST_LAST) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (all_halt) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_next = PRINT;
                    end else begin
                        state_next = DRAIN;
                    end
                end else if (timeout_hit) begin
                    state_next   = PRINT;
                    timeout_next = 1'b1;
                end
            end
            DRAIN: begin
                if (phase_cnt == DRAIN_LAST) begin
                    state_next = PRINT;
                end
            end
            PRINT: begin
                if (print_ack) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = RST_HOLD;
            end
        endcase
    end

    sim_cnt #(.W(PH_W)) u_phase_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    ((state_reg == RST_HOLD) || (state_reg == DRAIN)),
        .clr   (state_next != state_reg),
        .q     (phase_cnt)
    );

    sim_cnt #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_reg == RUN),
        .clr   (1'b0),
        .q     (cnt_q)
    );

    // Outputs are decoded from the next state so they change on the same edge as the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= RST_HOLD;
            mask_reg       <= '0;
            timeout_reg    <= 1'b0;
            print_reg      <= 1'b0;
            done_reg       <= 1'b0;
            proc_rst_n_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            mask_reg       <= mask_next;
            timeout_reg    <= timeout_next;
            print_reg      <= (state_next == PRINT);
            done_reg       <= (state_next == DONE);
            proc_rst_n_reg <= (state_next != RST_HOLD);
        end
    end

    assign proc_rst_n  = proc_rst_n_reg;
    assign print       = print_reg;
    assign cycle_cnt   = cnt_q;
    assign halted_mask = mask_reg;
    assign done        = done_reg;
    assign timeout     = timeout_reg;

endmodule

// File: doc/sim_ctrl.md
SIM_CTRL -- requirements
Module: sim_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NUM_CORES, 1, number of processor halt channels monitored
- CNT_W, 32, width of cycle counter
- RST_CYCLES, 4, cycles proc_rst_n is held low after rst_n release (>=1)
- DRAIN_CYCLES, 3, cycles waited after all-halt before print request (>=0)
- TIMEOUT, 100000, cycle limit in RUN before forced end (0 = disabled)
REQ-002 Ports SHALL be, one per line: name direction width meaning.
- clk input 1 single clock; all state changes on rising edge
- rst_n input 1 asynchronous, active-low reset
- halt input NUM_CORES per-core halt level, synchronous to clk
- proc_rst_n output 1 generated active-low reset to processor(s)
- print output 1 memory/register dump request, level
- print_ack input 1 dump complete, single-cycle pulse
- cycle_cnt output CNT_W cycles spent in RUN
- halted_mask output NUM_CORES sticky per-core halt record
- done output 1 end of simulation, level
- timeout output 1 end caused by TIMEOUT, level

Function
REQ-003 FSM SHALL have states RST_HOLD, RUN, DRAIN, PRINT, DONE.
REQ-004 RST_HOLD SHALL hold proc_rst_n=0 for exactly RST_CYCLES cycles after rst_n deasserts, then enter RUN with proc_rst_n=1 from the same edge.
REQ-005 In RUN cycle_cnt SHALL increment by 1 per cycle, saturating at all-ones (no wrap).
REQ-006 halted_mask[i] SHALL set on any cycle in RUN where halt[i]=1 and stay set until reset; deasserting halt[i] SHALL NOT clear it.
REQ-007 When halted_mask (including the current cycle's halt) is all-ones, RUN SHALL go to DRAIN on the next edge; cycle_cnt SHALL freeze at the value including that cycle.
REQ-008 DRAIN SHALL last DRAIN_CYCLES cycles (0 = pass straight to PRINT), then enter PRINT.
REQ-009 If TIMEOUT!=0 and cycle_cnt reaches TIMEOUT while not all halted, RUN SHALL go to PRINT and timeout SHALL set; if all-halt and timeout coincide the same cycle, all-halt SHALL win (timeout=0).
REQ-010 print SHALL be 1 exactly while in PRINT; print_ack in PRINT SHALL move to DONE next edge; print_ack outside PRINT SHALL be ignored.
REQ-011 DONE SHALL be terminal: done=1, print=0, proc_rst_n=1, cycle_cnt and halted_mask held, until rst_n.
REQ-012 halt in RST_HOLD SHALL be ignored.

Reset
REQ-013 rst_n=0 SHALL asynchronously force: state=RST_HOLD, proc_rst_n=0, print=0, done=0, timeout=0, cycle_cnt=0, halted_mask=0, internal counters=0.
REQ-014 Reset asserted mid-operation (any state, including PRINT awaiting ack) SHALL abort immediately to REQ-013 values; sequence restarts from REQ-004.

Structure
REQ-015 State encoding typedef and default parameter constants SHALL live in shared package sim_pkg.
REQ-016 One sub-module SHALL be used: sim_cnt, a parametrised saturating counter (width, enable, clear) instantiated for cycle_cnt and for the RST_HOLD/DRAIN counter.
REQ-017 All outputs SHALL be registered; no combinational input-to-output path.

Verification
REQ-018 Bench SHALL cover:
- Reset release, RST_CYCLES=4 -> proc_rst_n low 4 cycles then high, cycle_cnt starts 0.
- NUM_CORES=2, halt[0] at RUN cycle 10, halt[1] at 20, DRAIN_CYCLES=3 -> halted_mask=2'b11, cycle_cnt=21, print rises 4 cycles after halt[1]; ack -> done=1, timeout=0.
- TIMEOUT=50, no halt -> print at cycle_cnt=50, timeout=1; ack -> done=1.
- halt on the cycle cycle_cnt reaches TIMEOUT -> DRAIN path, timeout=0.
- rst_n pulsed low while print=1 -> print=0, proc_rst_n=0 same time step; full sequence repeats.
- CNT_W=4, TIMEOUT=0, halt at cycle 20 -> cycle_cnt saturates at 15, done after ack.
